gon_y_id_config_ctrl: RTL and testbench
=======================================

Name: gon_y_id_config_ctrl

Overview:
Configuration sequencer for one GON Y-bus column.
- Loads the per-PE row IDs into the bus's multicast controllers through the ROW_LEN-wide ID scan chain, driving set_id, id_scan_in and sampling id_scan_out.
- Holds a host-writable ID table.
- Runs a load pass and an optional verify (readback) pass, then reports done/error.
- Sits between the global configuration/host interface and each Y bus instance; connects directly to the bus's set_id, id_scan_in and id_scan_out.

Parameters:
MASTER_NUMS, 14, number of multicast controllers (chain length) on the Y bus
ROW_LEN, 4, width of one row ID / scan-chain slice
ADDR_LEN, 4, ID-table address width; must satisfy 2^ADDR_LEN >= MASTER_NUMS

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-low (asserted when 0)
cfg_we  input  1  ID-table write strobe
cfg_addr  input  ADDR_LEN  table index (= master index on the bus)
cfg_wdata  input  ROW_LEN  row ID for that master
start  input  1  begin a configuration sequence
verify_en  input  1  sampled with start; 1 = run verify pass
busy  output  1  sequence in progress
done  output  1  one-cycle completion pulse
error  output  1  verify mismatch flag, sticky until next accepted start
err_index  output  ADDR_LEN  master index of the first mismatch
set_id  output  1  scan-chain shift enable to the bus
id_scan_in  output  ROW_LEN  scan data into master 0
id_scan_out  input  ROW_LEN  scan data out of master MASTER_NUMS-1 (registered in the bus)

Behaviour:
- Reset (rst==0 at a clk edge):
  - state=IDLE; all ID-table entries=0; shift counter=0.
  - busy=0, done=0, error=0, err_index=0, set_id=0, id_scan_in=0.
  - Applies from the edge after reset is sampled, including mid-sequence: the sequence is aborted and the chain contents are undefined. No resume.
- Table writes:
  - Accepted only in IDLE when cfg_we=1 and cfg_addr<MASTER_NUMS.
  - Ignored otherwise (out-of-range address, busy, reset). Written data is visible to a start in the next cycle.
- start:
  - Accepted only in IDLE. Ignored while busy, with no queuing.
  - verify_en is latched at acceptance. error and err_index clear at acceptance.
- Scan order:
  - The chain shifts master i -> i+1 each cycle set_id=1.
  - Shift k (k=0..MASTER_NUMS-1) drives id_scan_in = table[MASTER_NUMS-1-k], so table[i] lands in master i after MASTER_NUMS shifts.
- States:
  - IDLE: set_id=0, busy=0. Accepted start -> LOAD with k=0.
  - LOAD: set_id=1, busy=1, exactly MASTER_NUMS cycles. At k=MASTER_NUMS-1 -> VERIFY if verify_en, else FINISH.
  - VERIFY: set_id=1, busy=1, MASTER_NUMS cycles, re-shifting the same sequence. Each cycle compare id_scan_out (pre-edge value, which equals master MASTER_NUMS-1-k) against the id_scan_in being driven. On the first mismatch: error<=1, err_index<=MASTER_NUMS-1-k. Later mismatches do not update err_index. The pass always completes, so the chain ends holding the table.
  - FINISH: one cycle, set_id=0, busy=1, done=1 -> IDLE.
- Latency: start accepted at edge t.
  - set_id is high for cycles t+1..t+MASTER_NUMS (LOAD), plus t+MASTER_NUMS+1..t+2*MASTER_NUMS if verifying.
  - done is high in cycle t+MASTER_NUMS+1 without verify, or t+2*MASTER_NUMS+1 with verify.
- Outputs are registered. id_scan_in is 0 whenever set_id=0.
- set_id is never asserted for more than 2*MASTER_NUMS consecutive cycles.
- Counter is ADDR_LEN bits and wraps to 0 on every state change; no arithmetic overflow beyond MASTER_NUMS-1.
- start asserted in the same cycle as a FINISH -> ignored (not IDLE).

Test Plan:
- Reset: hold rst=0 2 cycles with start=1 and cfg_we=1 -> all outputs 0, table unchanged at 0; first start after release loads all-zero IDs.
- Load without verify: write table[i]=i%16, start with verify_en=0 at t -> set_id high cycles t+1..t+14, id_scan_in sequence 13,12,...,0, done pulse at t+15; a bus model shows master i holds ID i.
- Load with verify on an ideal chain model: same table, verify_en=1 -> 28 cycles of set_id, done at t+29, error=0, chain still holds table.
- Fault injection: chain model forces master 5 to a stuck value 4'hF during verify -> error=1, err_index=5, done still pulses at t+29, error stays 1 until next start.
- Illegal accesses: cfg_we with cfg_addr=14 and 15, a cfg_we during busy, and start asserted mid-LOAD and during FINISH -> table and sequence unaffected; done pulses exactly once.
- Reset mid-LOAD at k=6 -> next cycle set_id=0, busy=0; a new start performs the full 14-shift sequence.

Source files
------------

// File: rtl/gon_y_id_config_ctrl.sv
// ID scan-chain configuration sequencer for one GON Y-bus column: holds a host-written row-ID
// table, shifts it into the bus multicast controllers, and can read it back to verify it.
module gon_y_id_config_ctrl #(
  parameter int unsigned MASTER_NUMS = 14,
  parameter int unsigned ROW_LEN     = 4,
  parameter int unsigned ADDR_LEN    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_we,
  input  logic [ADDR_LEN-1:0] cfg_addr,
  input  logic [ROW_LEN-1:0]  cfg_wdata,
  input  logic                start,
  input  logic                verify_en,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [ADDR_LEN-1:0] err_index,
  output logic                set_id,
  output logic [ROW_LEN-1:0]  id_scan_in,
  input  logic [ROW_LEN-1:0]  id_scan_out
);

  typedef enum logic [1:0] {StIdle, StLoad, StVerify, StFinish} state_e;

  localparam logic [ADDR_LEN-1:0] LastIdx = ADDR_LEN'(MASTER_NUMS - 1);

  logic [ROW_LEN-1:0]  id_table_q [MASTER_NUMS];
  state_e              state_q, state_d;
  logic [ADDR_LEN-1:0] cnt_q, cnt_d;
  logic                verify_q, verify_d;
  logic                error_q, error_d;
  logic [ADDR_LEN-1:0] err_index_q, err_index_d;
  logic                set_id_q, busy_q, done_q;
  logic [ROW_LEN-1:0]  id_scan_in_q, scan_d;
  logic                table_we;
  logic                shifting_d;

  assign table_we = (state_q == StIdle) && cfg_we && (32'(cfg_addr) < MASTER_NUMS);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    verify_d    = verify_q;
    error_d     = error_q;
    err_index_d = err_index_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d     = StLoad;
          cnt_d       = '0;
          verify_d    = verify_en;
          error_d     = 1'b0;
          err_index_d = '0;
        end
      end
      StLoad: begin
        if (cnt_q == LastIdx) begin
          state_d = verify_q ? StVerify : StFinish;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StVerify: begin
        // Readback of shift k is the ID of master LastIdx-k; only the first mismatch is recorded.
        if ((id_scan_out != id_scan_in_q) && !error_q) begin
          error_d     = 1'b1;
          err_index_d = LastIdx - cnt_q;
        end
        if (cnt_q == LastIdx) begin
          state_d = StFinish;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StFinish: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  assign shifting_d = (state_d == StLoad) || (state_d == StVerify);

  // Highest-index entry goes first so table[i] settles in master i after the full pass.
  always_comb begin
    scan_d = '0;
    if (shifting_d) begin
      scan_d = id_table_q[LastIdx - cnt_d];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      verify_q     <= 1'b0;
      error_q      <= 1'b0;
      err_index_q  <= '0;
      set_id_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      id_scan_in_q <= '0;
      for (int i = 0; i < int'(MASTER_NUMS); i++) begin
        id_table_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      verify_q     <= verify_d;
      error_q      <= error_d;
      err_index_q  <= err_index_d;
      set_id_q     <= shifting_d;
      busy_q       <= (state_d != StIdle);
      done_q       <= (state_d == StFinish);
      id_scan_in_q <= scan_d;
      if (table_we) begin
        id_table_q[cfg_addr] <= cfg_wdata;
      end
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign err_index  = err_index_q;
  assign set_id     = set_id_q;
  assign id_scan_in = id_scan_in_q;

endmodule

// File: tb/tb_gon_y_id_config_ctrl.sv
// Bench for gon_y_id_config_ctrl: table-driven writes and scenarios, random sequences,
// and a scan-chain bus model with an optional stuck master.
module tb_gon_y_id_config_ctrl;

  localparam int N  = 14;
  localparam int RL = 4;
  localparam int AL = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_we;
  logic [AL-1:0] cfg_addr;
  logic [RL-1:0] cfg_wdata;
  logic          start;
  logic          verify_en;
  logic          busy, done, error, set_id;
  logic [AL-1:0] err_index;
  logic [RL-1:0] id_scan_in, id_scan_out;

  gon_y_id_config_ctrl #(.MASTER_NUMS(N), .ROW_LEN(RL), .ADDR_LEN(AL)) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_wdata  (cfg_wdata),
    .start      (start),
    .verify_en  (verify_en),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .err_index  (err_index),
    .set_id     (set_id),
    .id_scan_in (id_scan_in),
    .id_scan_out(id_scan_out)
  );

  always #5 clk = ~clk;

  // Bus model: chain of N registered masters, master fm optionally passes a stuck value fv.
  logic [RL-1:0] chain [N];
  logic          fault_en = 1'b0;
  int            fm = 0;
  logic [RL-1:0] fv = '0;

  always @(posedge clk) begin
    if (set_id) begin
      chain[0] <= id_scan_in;
      for (int i = 1; i < N; i++) chain[i] <= (fault_en && (i - 1 == fm)) ? fv : chain[i-1];
    end
  end
  assign id_scan_out = chain[N-1];

  // Reference table contents as the host intends them.
  logic [RL-1:0] tbl [N];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < N; i++) tbl[i] = '0;
  endtask

  task automatic write(input logic [AL-1:0] a, input logic [RL-1:0] d);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    @(negedge clk);
    cfg_we = 1'b0;
    if (int'(a) < N) tbl[a] = d;
  endtask

  // With master m passing v, readback of master j is v for j<=m; first mismatch is highest such j.
  function automatic int exp_err_idx(input int m, input logic [RL-1:0] v);
    for (int j = m; j >= 0; j--) if (tbl[j] != v) return j;
    return -1;
  endfunction

  task automatic run_seq(input bit ver, input bit flt, input int m, input logic [RL-1:0] v,
                         input bit poke);
    int len, k, dones, e;
    bit chain_ok;
    len = ver ? 2 * N : N;
    dones = 0;
    fm = m; fv = v;
    e = (ver && flt) ? exp_err_idx(m, v) : -1;
    @(negedge clk);
    start = 1'b1; verify_en = ver;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; verify_en = 1'b0;
    chk("error_clear_at_start", {31'd0, error}, 0);
    for (int c = 1; c <= len + 2; c++) begin
      start = 1'b0;
      cfg_we = 1'b0;
      if (flt && c == N + 1) fault_en = 1'b1;
      if (poke && c == 3) begin
        start = 1'b1; cfg_we = 1'b1; cfg_addr = '0; cfg_wdata = ~tbl[0];
      end
      if (poke && c == len + 1) start = 1'b1;
      k = (c - 1) % N;
      chk($sformatf("set_id c=%0d", c), {31'd0, set_id}, {31'd0, c <= len});
      chk($sformatf("busy c=%0d", c), {31'd0, busy}, {31'd0, c <= len + 1});
      chk($sformatf("id_scan_in c=%0d", c), {28'd0, id_scan_in},
          (c <= len) ? {28'd0, tbl[N-1-k]} : 32'd0);
      if (done) dones++;
      chk($sformatf("done c=%0d", c), {31'd0, done}, {31'd0, c == len + 1});
      @(negedge clk);
    end
    start = 1'b0; cfg_we = 1'b0; fault_en = 1'b0;
    chk("done_count", dones, 1);
    chk("error", {31'd0, error}, {31'd0, e >= 0});
    chk("err_index", {28'd0, err_index}, (e >= 0) ? e : 0);
    if (!(ver && flt)) begin
      chain_ok = 1'b1;
      for (int i = 0; i < N; i++) if (chain[i] !== tbl[i]) chain_ok = 1'b0;
      chk("chain_holds_table", {31'd0, chain_ok}, 1);
    end
    repeat (2) @(negedge clk);
    chk("error_sticky", {31'd0, error}, {31'd0, e >= 0});
  endtask

  typedef struct {
    logic [AL-1:0] addr;
    logic [RL-1:0] data;
  } wr_t;

  typedef struct {
    bit            ver;
    bit            flt;
    int            m;
    logic [RL-1:0] v;
    bit            poke;
  } scen_t;

  wr_t   wvec [N+2];
  scen_t svec [5];

  initial begin
    rst = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0; start = 1'b0; verify_en = 1'b0;
    for (int i = 0; i < N; i++) wvec[i] = '{addr: AL'(i), data: RL'(i % 16)};
    wvec[N]   = '{addr: 4'd14, data: 4'h7};
    wvec[N+1] = '{addr: 4'd15, data: 4'h9};
    svec[0] = '{ver: 1'b0, flt: 1'b0, m: 0, v: 4'h0, poke: 1'b0};
    svec[1] = '{ver: 1'b1, flt: 1'b0, m: 0, v: 4'h0, poke: 1'b0};
    svec[2] = '{ver: 1'b1, flt: 1'b1, m: 5, v: 4'hF, poke: 1'b0};
    svec[3] = '{ver: 1'b0, flt: 1'b0, m: 0, v: 4'h0, poke: 1'b1};
    svec[4] = '{ver: 1'b1, flt: 1'b0, m: 0, v: 4'h0, poke: 1'b1};
    clear_model();

    // Reset held with start and a write pending.
    start = 1'b1; cfg_we = 1'b1; cfg_addr = 4'd3; cfg_wdata = 4'h5;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_error", {31'd0, error}, 0);
    chk("rst_err_index", {28'd0, err_index}, 0);
    chk("rst_set_id", {31'd0, set_id}, 0);
    chk("rst_id_scan_in", {28'd0, id_scan_in}, 0);
    start = 1'b0; cfg_we = 1'b0; rst = 1'b1;
    run_seq(1'b1, 1'b0, 0, 4'h0, 1'b0);

    for (int i = 0; i < N + 2; i++) write(wvec[i].addr, wvec[i].data);
    for (int s = 0; s < 5; s++) run_seq(svec[s].ver, svec[s].flt, svec[s].m, svec[s].v, svec[s].poke);

    // Reset in the middle of LOAD at k=6.
    @(negedge clk);
    start = 1'b1; verify_en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_set_id", {31'd0, set_id}, 0);
    chk("midrst_busy", {31'd0, busy}, 0);
    chk("midrst_id_scan_in", {28'd0, id_scan_in}, 0);
    rst = 1'b1;
    clear_model();
    run_seq(1'b0, 1'b0, 0, 4'h0, 1'b0);

    for (int it = 0; it < 6; it++) begin
      for (int w = 0; w < 18; w++) write(AL'($urandom_range(0, 15)), RL'($urandom));
      begin
        bit rv, rf;
        rv = 1'($urandom);
        rf = rv && 1'($urandom);
        run_seq(rv, rf, $urandom_range(0, N - 1), RL'($urandom), 1'($urandom));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
